// File: rtl/octree_mem_pkg.sv
// Shared types and helpers for the Octree SRAM port.
// Holds the default geometry of the Octree memory port, the request/tag
// record layouts at that default geometry, and the round-robin pointer
// advance used by the arbiter front end.
package octree_mem_pkg;

    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_RD_LATENCY = 1;

    typedef struct packed {
        logic                      we;
        logic                      lock;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                   vld;
        logic [DEF_NUM_REQ-1:0] id;
    } mem_tag_t;

    // Pointer to the requester after 'ptr', wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/octree_sram_arbiter_rr_arbiter.sv
// Round-robin grant logic with burst lock.
// Ports:
//   req        in  NUM_REQ  request vector
//   lock_en    in  1        a burst lock is held
//   lock_owner in  IDX_W    index of the lock holder
//   rr_ptr     in  IDX_W    highest-priority requester when unlocked
//   grant      out NUM_REQ  one-hot grant (all zero when nothing granted)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               lock_en,
    input  logic [IDX_W-1:0]   lock_owner,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Unlocked search: first pass covers [rr_ptr, NUM_REQ-1], second pass
    // wraps to [0, rr_ptr-1]; 'found' keeps the result one-hot.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (lock_en) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (i == 32'(lock_owner)) begin
                    grant[i] = req[i];
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && i >= 32'(rr_ptr)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && i < 32'(rr_ptr)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/octree_sram_arbiter.sv
// N-requester front end to one single-port synchronous SRAM macro.
// Round-robin arbitration with optional burst lock; all SRAM pins are
// registered and read data is steered back by a tag pipeline.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready       per-requester handshake (ready = grant)
//   req_we/lock           per-requester write flag / hold grant after beat
//   req_addr/wdata        per-requester address / write data
//   rsp_valid             one-hot read-data strobe
//   rsp_rdata             read data (zero when no strobe)
//   sram_cen_n/gwen/a/d   registered SRAM pins
//   sram_q                SRAM read data
module octree_sram_arbiter
    import octree_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0]                   req_lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 sram_cen_n,
    output logic                                 sram_gwen,
    output logic [ADDR_WIDTH-1:0]                sram_a,
    output logic [DATA_WIDTH-1:0]                sram_d,
    input  logic [DATA_WIDTH-1:0]                sram_q
);

    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TAG_DEPTH = RD_LATENCY + 1;

    typedef struct packed {
        logic                  we;
        logic                  lock;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } beat_t;

    typedef struct packed {
        logic               vld;
        logic [NUM_REQ-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  rd_accept;
    int unsigned           sel_idx;
    beat_t                 sel;

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      lock_owner_q, lock_owner_d;
    logic                  lock_q, lock_d;
    logic                  cen_n_q, cen_n_d;
    logic                  gwen_q, gwen_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    tag_t                  tag_q [TAG_DEPTH];
    tag_t                  tag_d [TAG_DEPTH];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .lock_en    (lock_q),
        .lock_owner (lock_owner_q),
        .rr_ptr     (rr_ptr_q),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign rd_accept = accept & ~sel.we;

    // Select the granted requester's beat.
    always_comb begin
        sel_idx = 0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx = i;
                sel     = '{we: req_we[i], lock: req_lock[i],
                            addr: req_addr[i], wdata: req_wdata[i]};
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        cen_n_d      = 1'b1;
        gwen_d       = 1'b1;
        a_d          = a_q;
        d_d          = d_q;
        // Tag enters at stage 0 on the accept edge and reaches the last
        // stage in cycle accept+1+RD_LATENCY, aligned with valid sram_q.
        tag_d[0] = '{vld: rd_accept, id: grant & {NUM_REQ{rd_accept}}};
        for (int unsigned k = 1; k < TAG_DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (accept) begin
            rr_ptr_d     = IDX_W'(rr_next(sel_idx, NUM_REQ));
            lock_d       = sel.lock;
            lock_owner_d = sel.lock ? IDX_W'(sel_idx) : lock_owner_q;
            cen_n_d      = 1'b0;
            gwen_d       = ~sel.we;
            a_d          = sel.addr;
            d_d          = sel.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
            cen_n_q      <= 1'b1;
            gwen_q       <= 1'b1;
            a_q          <= '0;
            d_q          <= '0;
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            cen_n_q      <= cen_n_d;
            gwen_q       <= gwen_d;
            a_q          <= a_d;
            d_q          <= d_d;
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign sram_cen_n = cen_n_q;
    assign sram_gwen  = gwen_q;
    assign sram_a     = a_q;
    assign sram_d     = d_q;

    assign rsp_valid = tag_q[TAG_DEPTH-1].vld ? tag_q[TAG_DEPTH-1].id : '0;
    assign rsp_rdata = (|rsp_valid) ? sram_q : '0;

endmodule

// File: tb/tb_octree_sram_arbiter.sv
module tb_octree_sram_arbiter;

    localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] D7 = 64'h0000_0000_0000_1234;
    localparam logic [63:0] W1 = 64'hDEAD_BEEF_0000_0040;
    localparam logic [63:0] W2 = 64'hDEAD_BEEF_0000_0041;
    localparam logic [63:0] W3 = 64'hDEAD_BEEF_0000_0042;
    localparam int unsigned NROWS = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: NUM_REQ=2, RD_LATENCY=1
    logic [1:0]       v0, rdy0, we0, lk0, rspv0;
    logic [1:0][5:0]  addr0;
    logic [1:0][63:0] wd0;
    logic [63:0]      rdata0, sd0, q0;
    logic             cen0, gwen0;
    logic [5:0]       sa0;

    // Instance 1: NUM_REQ=3, RD_LATENCY=2
    logic [2:0]       v1, rdy1, we1, lk1, rspv1;
    logic [2:0][5:0]  addr1;
    logic [2:0][63:0] wd1;
    logic [63:0]      rdata1, sd1, q1, q1a;
    logic             cen1, gwen1;
    logic [5:0]       sa1;

    octree_sram_arbiter u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_lock(lk0),
        .req_addr(addr0), .req_wdata(wd0),
        .rsp_valid(rspv0), .rsp_rdata(rdata0),
        .sram_cen_n(cen0), .sram_gwen(gwen0), .sram_a(sa0), .sram_d(sd0),
        .sram_q(q0)
    );

    octree_sram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(64), .RD_LATENCY(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_we(we1), .req_lock(lk1),
        .req_addr(addr1), .req_wdata(wd1),
        .rsp_valid(rspv1), .rsp_rdata(rdata1),
        .sram_cen_n(cen1), .sram_gwen(gwen1), .sram_a(sa1), .sram_d(sd1),
        .sram_q(q1)
    );

    function automatic logic [63:0] p0(input int unsigned i);
        return 64'h5EED_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] p1(input int unsigned i);
        return {32'hBEEF_0000 + i, ~i};
    endfunction

    // SRAM macro models
    logic [63:0] mem0 [64];
    logic [63:0] mem1 [64];
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= p0(32'(i));
                mem1[i] <= p1(32'(i));
            end
            init_done <= 1'b1;
        end else begin
            if (!cen0) begin
                if (!gwen0) mem0[sa0] <= sd0;
                else        q0 <= mem0[sa0];
            end
            if (!cen1) begin
                if (!gwen1) mem1[sa1] <= sd1;
                else        q1a <= mem1[sa1];
            end
            q1 <= q1a;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  v, we, lk;
        logic [5:0]  a0, a1;
        logic [63:0] wd0, wd1;
        logic [1:0]  rdy;
        logic        cen_n, gwen;
        logic [5:0]  a;
        logic [63:0] d;
        logic [1:0]  rspv;
        logic [63:0] rdata;
    } vec_t;

    vec_t tbl [NROWS];

    logic [2:0]  exp_id  [80];
    logic [63:0] exp_dat [80];

    initial begin
        // inputs: v, we, lk, a0, a1, wd0, wd1 | expected: rdy, cen_n, gwen, a, d, rspv, rdata
        // single write then read
        tbl[0]  = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[1]  = '{2'b01,2'b01,2'b00,6'd1, 6'd0, A5,   64'd0, 2'b01,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[2]  = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b0,6'd1, A5,   2'b00,64'd0};
        tbl[3]  = '{2'b01,2'b00,2'b00,6'd1, 6'd0, 64'd0,64'd0, 2'b01,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[4]  = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd1, 64'd0,2'b00,64'd0};
        tbl[5]  = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b01,A5};
        // read-after-write hazard across requesters
        tbl[6]  = '{2'b01,2'b01,2'b00,6'd7, 6'd0, D7,   64'd0, 2'b01,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[7]  = '{2'b10,2'b00,2'b00,6'd0, 6'd7, 64'd0,64'd0, 2'b10,1'b0,1'b0,6'd7, D7,   2'b00,64'd0};
        // round-robin with both requesters reading
        tbl[8]  = '{2'b11,2'b00,2'b00,6'd10,6'd20,64'd0,64'd0, 2'b01,1'b0,1'b1,6'd7, 64'd0,2'b00,64'd0};
        tbl[9]  = '{2'b11,2'b00,2'b00,6'd11,6'd21,64'd0,64'd0, 2'b10,1'b0,1'b1,6'd10,64'd0,2'b10,D7};
        tbl[10] = '{2'b11,2'b00,2'b00,6'd12,6'd22,64'd0,64'd0, 2'b01,1'b0,1'b1,6'd21,64'd0,2'b01,p0(10)};
        tbl[11] = '{2'b11,2'b00,2'b00,6'd13,6'd23,64'd0,64'd0, 2'b10,1'b0,1'b1,6'd12,64'd0,2'b10,p0(21)};
        tbl[12] = '{2'b11,2'b00,2'b00,6'd14,6'd24,64'd0,64'd0, 2'b01,1'b0,1'b1,6'd23,64'd0,2'b01,p0(12)};
        tbl[13] = '{2'b11,2'b00,2'b00,6'd15,6'd25,64'd0,64'd0, 2'b10,1'b0,1'b1,6'd14,64'd0,2'b10,p0(23)};
        tbl[14] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd25,64'd0,2'b01,p0(14)};
        tbl[15] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b10,p0(25)};
        // burst lock: R1 writes with lock 1,1,0 while R0 waits
        tbl[16] = '{2'b01,2'b00,2'b00,6'd30,6'd0, 64'd0,64'd0, 2'b01,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[17] = '{2'b11,2'b10,2'b10,6'd31,6'd40,64'd0,W1,    2'b10,1'b0,1'b1,6'd30,64'd0,2'b00,64'd0};
        tbl[18] = '{2'b11,2'b10,2'b10,6'd31,6'd41,64'd0,W2,    2'b10,1'b0,1'b0,6'd40,W1,   2'b01,p0(30)};
        tbl[19] = '{2'b11,2'b10,2'b00,6'd31,6'd42,64'd0,W3,    2'b10,1'b0,1'b0,6'd41,W2,   2'b00,64'd0};
        tbl[20] = '{2'b01,2'b00,2'b00,6'd31,6'd0, 64'd0,64'd0, 2'b01,1'b0,1'b0,6'd42,W3,   2'b00,64'd0};
        tbl[21] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd31,64'd0,2'b00,64'd0};
        tbl[22] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b01,p0(31)};
        // lock holder drops valid: other requester stalls
        tbl[23] = '{2'b10,2'b00,2'b10,6'd0, 6'd50,64'd0,64'd0, 2'b10,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[24] = '{2'b01,2'b00,2'b00,6'd51,6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd50,64'd0,2'b00,64'd0};
        tbl[25] = '{2'b11,2'b00,2'b00,6'd51,6'd52,64'd0,64'd0, 2'b10,1'b1,1'b1,6'd0, 64'd0,2'b10,p0(50)};
        tbl[26] = '{2'b01,2'b00,2'b00,6'd51,6'd0, 64'd0,64'd0, 2'b01,1'b0,1'b1,6'd52,64'd0,2'b00,64'd0};
        tbl[27] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd51,64'd0,2'b10,p0(52)};
        tbl[28] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b01,p0(51)};
        // read back a locked-burst write
        tbl[29] = '{2'b01,2'b00,2'b00,6'd41,6'd0, 64'd0,64'd0, 2'b01,1'b1,1'b1,6'd0, 64'd0,2'b00,64'd0};
        tbl[30] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b0,1'b1,6'd41,64'd0,2'b00,64'd0};
        tbl[31] = '{2'b00,2'b00,2'b00,6'd0, 6'd0, 64'd0,64'd0, 2'b00,1'b1,1'b1,6'd0, 64'd0,2'b01,W2};

        rst_n = 1'b0;
        v0 = '0; we0 = '0; lk0 = '0; addr0 = '0; wd0 = '0;
        v1 = '0; we1 = '0; lk1 = '0; addr1 = '0; wd1 = '0;

        // Reset values, then a read interrupted by reset
        repeat (2) @(negedge clk);
        chk("rst_cen_n", 64'(cen0), 64'd1);
        chk("rst_gwen", 64'(gwen0), 64'd1);
        chk("rst_sram_a", 64'(sa0), 64'd0);
        chk("rst_sram_d", sd0, 64'd0);
        chk("rst_ready", 64'(rdy0), 64'd0);
        chk("rst_rsp_valid", 64'(rspv0), 64'd0);
        chk("rst_rsp_rdata", rdata0, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        v0 = 2'b01; we0 = 2'b00; addr0[0] = 6'd5;
        @(negedge clk);
        chk("midrd_ready", 64'(rdy0), 64'd1);
        @(posedge clk); #1;
        v0 = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrd_rsp_valid_%0d", i), 64'(rspv0), 64'd0);
            chk($sformatf("midrd_cen_n_%0d", i), 64'(cen0), 64'd1);
            chk($sformatf("midrd_gwen_%0d", i), 64'(gwen0), 64'd1);
        end
        rst_n = 1'b1;

        // Directed vector table on instance 0
        for (int r = 0; r < int'(NROWS); r++) begin
            @(posedge clk); #1;
            v0 = tbl[r].v; we0 = tbl[r].we; lk0 = tbl[r].lk;
            addr0[0] = tbl[r].a0; addr0[1] = tbl[r].a1;
            wd0[0] = tbl[r].wd0; wd0[1] = tbl[r].wd1;
            @(negedge clk);
            chk($sformatf("row%0d_ready", r), 64'(rdy0), 64'(tbl[r].rdy));
            chk($sformatf("row%0d_cen_n", r), 64'(cen0), 64'(tbl[r].cen_n));
            chk($sformatf("row%0d_gwen", r), 64'(gwen0), 64'(tbl[r].gwen));
            if (!tbl[r].cen_n) chk($sformatf("row%0d_sram_a", r), 64'(sa0), 64'(tbl[r].a));
            if (!tbl[r].gwen)  chk($sformatf("row%0d_sram_d", r), sd0, tbl[r].d);
            chk($sformatf("row%0d_rsp_valid", r), 64'(rspv0), 64'(tbl[r].rspv));
            if (tbl[r].rspv != 2'b00) chk($sformatf("row%0d_rsp_rdata", r), rdata0, tbl[r].rdata);
        end
        v0 = '0;

        // Random reads on instance 1 (3 requesters, read latency 2)
        for (int c = 0; c < 80; c++) begin
            exp_id[c]  = '0;
            exp_dat[c] = '0;
        end
        begin
            int unsigned ptr_m;
            int unsigned g_idx;
            int unsigned idx;
            logic [2:0]  g_m;
            logic        found;
            ptr_m = 0;
            g_idx = 0;
            for (int c = 0; c < 48; c++) begin
                @(posedge clk); #1;
                if (c < 44) begin
                    v1 = 3'($urandom_range(0, 7));
                    for (int r = 0; r < 3; r++) addr1[r] = 6'($urandom_range(0, 63));
                end else begin
                    v1 = '0;
                end
                g_m   = '0;
                found = 1'b0;
                for (int unsigned k = 0; k < 3; k++) begin
                    idx = (ptr_m + k) % 3;
                    if (!found && v1[idx]) begin
                        g_m[idx] = 1'b1;
                        g_idx    = idx;
                        found    = 1'b1;
                    end
                end
                @(negedge clk);
                chk($sformatf("lat_c%0d_ready", c), 64'(rdy1), 64'(g_m));
                chk($sformatf("lat_c%0d_rsp_valid", c), 64'(rspv1), 64'(exp_id[c]));
                if (exp_id[c] != 3'b000) chk($sformatf("lat_c%0d_rsp_rdata", c), rdata1, exp_dat[c]);
                if (found) begin
                    ptr_m          = (g_idx + 1) % 3;
                    exp_id[c+3]    = g_m;
                    exp_dat[c+3]   = p1(32'(addr1[g_idx]));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
